// File: rtl/servo_source_scheduler_if.sv
// Bus bundle for the servo source scheduler: two angle sources in, and the
// slew-limited servo command plus scheduler status out.
interface servo_source_scheduler_if;
    logic        sel_req;
    logic [47:0] src0_abs;
    logic [2:0]  src0_neg;
    logic        src0_valid;
    logic [47:0] src1_abs;
    logic [2:0]  src1_neg;
    logic        src1_valid;
    logic [47:0] out_abs;
    logic [2:0]  out_neg;
    logic        grant;
    logic        switching;
    logic        settled;

    modport master (
        output sel_req, src0_abs, src0_neg, src0_valid, src1_abs, src1_neg, src1_valid,
        input  out_abs, out_neg, grant, switching, settled
    );

    modport slave (
        input  sel_req, src0_abs, src0_neg, src0_valid, src1_abs, src1_neg, src1_valid,
        output out_abs, out_neg, grant, switching, settled
    );
endinterface

// File: rtl/servo_source_scheduler.sv
// Grants the servo datapath to one angle source, slew-limits all three axes on a
// fixed tick and holds off further source changes after each completed switch.
module servo_source_scheduler #(
    parameter int TICK_CYCLES   = 500000,
    parameter int MAX_STEP      = 4,
    parameter int HOLDOFF_TICKS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    servo_source_scheduler_if.slave  bus
);
    localparam int TCW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HCW = (HOLDOFF_TICKS > 0) ? $clog2(HOLDOFF_TICKS + 1) : 1;
    localparam logic [TCW-1:0]     TICK_LAST = TCW'(TICK_CYCLES - 1);
    localparam logic [HCW-1:0]     HOLD_INIT = HCW'(HOLDOFF_TICKS);
    localparam logic signed [17:0] STEP18    = 18'(MAX_STEP);
    localparam logic signed [16:0] STEP17    = 17'(MAX_STEP);

    typedef enum logic [1:0] {
        ST_FOLLOW    = 2'd0,
        ST_SWITCHING = 2'd1,
        ST_HOLDOFF   = 2'd2
    } state_e;

    function automatic logic signed [16:0] to_signed17(input logic [15:0] mag, input logic neg);
        logic signed [16:0] v;
        v = $signed({1'b0, mag});
        return neg ? -v : v;
    endfunction

    // Differences are taken in 18 bits so a full-scale swing cannot wrap.
    function automatic logic signed [16:0] slew(input logic signed [16:0] pos,
                                                input logic signed [16:0] tgt);
        logic signed [17:0] d;
        d = $signed({tgt[16], tgt}) - $signed({pos[16], pos});
        if (d > STEP18) begin
            return pos + STEP17;
        end else if (d < -STEP18) begin
            return pos - STEP17;
        end else begin
            return tgt;
        end
    endfunction

    function automatic logic [15:0] mag16(input logic signed [16:0] p);
        return 16'(p[16] ? -p : p);
    endfunction

    state_e           state_q;
    logic [TCW-1:0]   tick_cnt_q;
    logic [HCW-1:0]   holdoff_cnt_q;
    logic             grant_q;
    logic             switching_q;
    logic [2:0][16:0] pos_q, tgt_q, pos_d, tgt_d;
    logic [47:0]      out_abs_q;
    logic [2:0]       out_neg_q;

    logic             tick_s;
    logic [47:0]      sel_abs_s;
    logic [2:0]       sel_neg_s;
    logic             sel_valid_s;
    logic             settled_s;
    logic             settled_next_s;

    // Next position (ramp on tick) and next target (capture from granted source).
    always_comb begin
        tick_s      = (tick_cnt_q == TICK_LAST);
        sel_abs_s   = grant_q ? bus.src1_abs   : bus.src0_abs;
        sel_neg_s   = grant_q ? bus.src1_neg   : bus.src0_neg;
        sel_valid_s = grant_q ? bus.src1_valid : bus.src0_valid;
        pos_d       = pos_q;
        tgt_d       = tgt_q;
        for (int a = 0; a < 3; a++) begin
            if (tick_s) begin
                pos_d[a] = slew(pos_q[a], tgt_q[a]);
            end else begin
                pos_d[a] = pos_q[a];
            end
            if (sel_valid_s) begin
                tgt_d[a] = to_signed17(sel_abs_s[16*a +: 16], sel_neg_s[a]);
            end else begin
                tgt_d[a] = tgt_q[a];
            end
        end
        settled_s      = (pos_q == tgt_q);
        settled_next_s = (pos_d == tgt_d);
    end

    // Tick counter, motion state, registered outputs and the grant state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FOLLOW;
            tick_cnt_q    <= '0;
            holdoff_cnt_q <= '0;
            grant_q       <= 1'b0;
            switching_q   <= 1'b0;
            pos_q         <= '0;
            tgt_q         <= '0;
            out_abs_q     <= '0;
            out_neg_q     <= '0;
        end else begin
            tick_cnt_q <= tick_s ? '0 : tick_cnt_q + TCW'(1);
            pos_q      <= pos_d;
            tgt_q      <= tgt_d;
            for (int a = 0; a < 3; a++) begin
                out_abs_q[16*a +: 16] <= mag16(pos_q[a]);
                out_neg_q[a]          <= pos_q[a][16];
            end
            case (state_q)
                ST_FOLLOW: begin
                    if (bus.sel_req != grant_q && holdoff_cnt_q == '0) begin
                        grant_q     <= bus.sel_req;
                        switching_q <= 1'b1;
                        state_q     <= ST_SWITCHING;
                    end
                end
                ST_SWITCHING: begin
                    if (tick_s && settled_next_s) begin
                        holdoff_cnt_q <= HOLD_INIT;
                        switching_q   <= 1'b0;
                        state_q       <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (holdoff_cnt_q == '0) begin
                        state_q <= ST_FOLLOW;
                    end else if (tick_s) begin
                        holdoff_cnt_q <= holdoff_cnt_q - HCW'(1);
                        if (holdoff_cnt_q == HCW'(1)) begin
                            state_q <= ST_FOLLOW;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_FOLLOW;
                    switching_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_abs   = out_abs_q;
    assign bus.out_neg   = out_neg_q;
    assign bus.grant     = grant_q;
    assign bus.switching = switching_q;
    assign bus.settled   = settled_s;
endmodule

// File: doc/servo_source_scheduler.md
Name: servo_source_scheduler

Overview:
- Sits between the angle sources (accelerometer reader, angle-sequence generator) and the three servo PWM controllers plus the hex-to-angle display converters.
- Grants the servo datapath to one source at a time.
- Slew-limits every axis toward the granted source's targets on a fixed tick.
- Enforces a hold-off after each source changeover, so switching modes never produces a servo jump or rapid toggling.

Parameters:
TICK_CYCLES, 500000, clk cycles per motion tick (10 ms at 50 MHz)
MAX_STEP, 4, max per-axis position change per tick, in angle LSBs
HOLDOFF_TICKS, 8, ticks after a completed switch before a new switch is accepted

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sel_req  in  1  requested source (level): 0 = accelerometer (src0), 1 = sequence (src1)
src0_abs  in  48  src0 magnitudes {z[47:32], y[31:16], x[15:0]}
src0_neg  in  3  src0 sign bits {z,y,x}, 1 = negative
src0_valid  in  1  src0 sample strobe
src1_abs  in  48  src1 magnitudes, same packing
src1_neg  in  3  src1 sign bits
src1_valid  in  1  src1 sample strobe
out_abs  out  48  slew-limited magnitudes to servos, same packing
out_neg  out  3  slew-limited sign bits
grant  out  1  source currently owning the targets
switching  out  1  high while in SWITCHING
settled  out  1  high when all three positions equal their targets

Behaviour:
- Reset (rst=1 at a clk edge):
  - pos, tgt = 0; out_abs = 0, out_neg = 0.
  - grant = 0, state = FOLLOW, holdoff_cnt = 0, tick counter = 0.
  - switching = 0, settled = 1.
  - Reset mid-switch or mid-ramp abandons it immediately; no ramp-down.
- Internal representation:
  - Per-axis signed 17-bit value: neg ? -abs : abs.
  - Input magnitudes are used in full (16 bits).
  - Differences are computed in 18 bits.
- Tick:
  - Counter runs 0..TICK_CYCLES-1; tick = 1 for one cycle when counter == TICK_CYCLES-1, then the counter wraps to 0.
  - The counter runs in all states.
- Target capture:
  - If valid of the granted source is high, tgt <= that source's values on that edge; visible to the ramp from the next cycle.
  - Valid of the non-granted source is ignored.
- Ramp, on tick only, all axes in the same cycle:
  - d = tgt - pos.
  - If |d| <= MAX_STEP: pos <= tgt; else pos <= pos + sign(d)*MAX_STEP.
  - A ramp crossing zero passes through 0 normally.
- Outputs:
  - out_abs = |pos|, out_neg = (pos < 0), registered (one cycle after pos updates).
  - Zero is always driven as neg = 0, including a -0 input.
- settled is combinational from pos == tgt on all axes.
- State machine:
  - FOLLOW: if sel_req != grant and holdoff_cnt == 0 -> grant <= sel_req, switching <= 1, go to SWITCHING. Targets then come from the new source; pos keeps its value, so motion to the new source is slew-limited.
  - SWITCHING: sel_req is ignored. When settled is observed on a tick edge after the ramp update -> holdoff_cnt <= HOLDOFF_TICKS, switching <= 0, go to HOLDOFF.
  - HOLDOFF: holdoff_cnt decrements on each tick. When it reaches 0 -> FOLLOW. sel_req is ignored.
  - A sel_req pulse that ends before FOLLOW re-samples it is lost (level semantics).
- Simultaneous events:
  - On a switch edge, the new source's valid on that same edge is not captured; the first capture is the next cycle.
  - Valid and tick on the same edge: the ramp uses the old tgt; the new tgt takes effect next tick.
- Latency: valid at edge n -> tgt at n+1 -> first pos change at the next tick -> out_* one cycle later.

Test Plan:
Use TICK_CYCLES=4, MAX_STEP=4, HOLDOFF_TICKS=2.
1. Reset with nonzero inputs and valids high -> out_abs=0, out_neg=0, grant=0, settled=1 until rst falls.
2. src0 x = +10, valid pulse -> out x goes 4, 8, 10 on successive ticks (+1 cycle); settled rises when pos reaches 10.
3. pos x = +6, src0 x = -6 (neg=1) -> sequence 2, -2 (abs=2, neg=1), -6; no out_neg glitch at zero.
4. tgt x = 20 settled, sel_req=1 with src1 x = 0 -> grant=1, switching=1; out x 16, 12, 8, 4, 0; switching drops; HOLDOFF lasts 2 ticks.
5. Toggle sel_req back to 0 during SWITCHING and HOLDOFF -> grant stays 1; a switch back starts only in FOLLOW.
6. Assert rst mid-switch -> next cycle: all outputs 0, grant=0, switching=0, state FOLLOW.
